// File: rtl/rms_vector_out_converter_pkg.sv
// Fixed-point formats and the RMS-to-matmul output conversion helpers.
package rms_vector_out_converter_pkg;

  localparam int unsigned D = 4;

  localparam int unsigned RmsFixedPointPrecision = 16;
  localparam int          RmsFixedPointExponent  = 3;
  localparam int unsigned FixedPointPrecision    = 8;
  localparam int          FixedPointExponent     = 0;

  localparam int          RmsOutShift      = RmsFixedPointExponent - FixedPointExponent;
  localparam int unsigned RmsOutShiftLeft  = (RmsOutShift > 0) ? unsigned'(RmsOutShift) : 0;
  localparam int unsigned RmsOutShiftRight = (RmsOutShift < 0) ? unsigned'(-RmsOutShift) : 0;
  localparam int unsigned RmsExtWidth      = RmsFixedPointPrecision + FixedPointPrecision;

  typedef logic signed [RmsFixedPointPrecision-1:0] rms_fixed_point_t;
  typedef logic signed [FixedPointPrecision-1:0]    fixed_point_t;
  typedef logic signed [RmsExtWidth-1:0]            rms_ext_t;
  typedef logic [D-1:0][RmsFixedPointPrecision-1:0] rms_vector_t;
  typedef logic [D-1:0][FixedPointPrecision-1:0]    vector_t;
  typedef logic [D-1:0]                             sat_flags_t;

  localparam fixed_point_t FixedPointMax = {1'b0, {(FixedPointPrecision-1){1'b1}}};
  localparam fixed_point_t FixedPointMin = {1'b1, {(FixedPointPrecision-1){1'b0}}};

  // Sign-extend and rescale to the output exponent; the wide format cannot overflow.
  function automatic rms_ext_t rms_internal2out_ext(input rms_fixed_point_t x);
    rms_ext_t e;
    e = RmsExtWidth'(x);
    e = e <<< RmsOutShiftLeft;
    e = e >>> RmsOutShiftRight;
    return e;
  endfunction

  function automatic fixed_point_t rms_internal2out_sat(input rms_fixed_point_t x,
                                                       output logic sat);
    rms_ext_t e;
    e = rms_internal2out_ext(x);
    if (e > rms_ext_t'(FixedPointMax)) begin
      sat = 1'b1;
      return FixedPointMax;
    end else if (e < rms_ext_t'(FixedPointMin)) begin
      sat = 1'b1;
      return FixedPointMin;
    end
    sat = 1'b0;
    return FixedPointPrecision'(e);
  endfunction

endpackage

// File: rtl/rms_vector_out_converter_sat_convert.sv
// Single-element RMS-to-output converter; flag reports out-of-range in both modes.
module rms_sat_convert
  import rms_vector_out_converter_pkg::*;
#(
  parameter bit Saturate = 1'b1
) (
  input  rms_fixed_point_t x,
  output fixed_point_t     y,
  output logic             sat
);

  fixed_point_t y_sat;
  fixed_point_t y_wrap;
  logic         flag;

  always_comb begin
    flag   = 1'b0;
    y_sat  = rms_internal2out_sat(x, flag);
    y_wrap = FixedPointPrecision'(rms_internal2out_ext(x));
  end

  assign y   = Saturate ? y_sat : y_wrap;
  assign sat = flag;

endmodule

// File: rtl/rms_vector_out_converter.sv
// Accepts one RMS vector, converts it one element per cycle, then holds the
// converted vector until the downstream handshake completes.
module rms_vector_out_converter
  import rms_vector_out_converter_pkg::*;
#(
  parameter int unsigned D        = rms_vector_out_converter_pkg::D,
  parameter bit          Saturate = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [D*RmsFixedPointPrecision-1:0]   in_vector_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [D*FixedPointPrecision-1:0]      out_vector_o,
  output logic [D-1:0]                          sat_flags_o
);

  localparam int unsigned IdxW = (D > 1) ? $clog2(D) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            accept;
  logic            convert;

  logic [D-1:0][RmsFixedPointPrecision-1:0] in_reg_q;
  logic [D-1:0][FixedPointPrecision-1:0]    out_vec_q;
  logic [D-1:0]                             sat_q;

  rms_fixed_point_t elem_x;
  fixed_point_t     elem_y;
  logic             elem_sat;

  // State register and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  // Next-state logic; the counter parks at D-1 instead of wrapping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    convert = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        convert = 1'b1;
        if (idx_q == IdxW'(D-1)) state_d = HOLD;
        else                     idx_d   = idx_q + 1'b1;
      end
      HOLD: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input register only changes on acceptance.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) in_reg_q <= in_vector_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vec_q <= '0;
      sat_q     <= '0;
    end else if (accept) begin
      sat_q <= '0;
    end else if (convert) begin
      out_vec_q[idx_q] <= elem_y;
      sat_q[idx_q]     <= elem_sat;
    end
  end

  assign elem_x = in_reg_q[idx_q];

  rms_sat_convert #(.Saturate(Saturate)) u_conv (
    .x   (elem_x),
    .y   (elem_y),
    .sat (elem_sat)
  );

  assign in_ready_o   = in_ready_q & ~rst_i;
  assign out_valid_o  = out_valid_q;
  assign out_vector_o = out_vec_q;
  assign sat_flags_o  = sat_q;

endmodule
